// File: rtl/intt_result_collector.sv
// Result sink for the INTT processor: captures one full output frame into a
// beat-addressed buffer, then streams it out one coefficient per handshake.
module intt_result_collector #(
  parameter int unsigned LOG_CORE_COUNT = 4,
  parameter int unsigned LOG_N          = 12,
  parameter int unsigned COEFF_WIDTH    = 30
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    in_active,
  input  logic [8:0]                                              in_address,
  input  logic [(1<<LOG_CORE_COUNT)-1:0][1:0][2*COEFF_WIDTH-1:0]  in_data,
  input  logic                                                    err_clear,
  output logic                                                    m_valid,
  input  logic                                                    m_ready,
  output logic [COEFF_WIDTH-1:0]                                  m_data,
  output logic [LOG_N-1:0]                                        m_index,
  output logic                                                    m_last,
  output logic                                                    busy,
  output logic                                                    frame_done,
  output logic                                                    err_short,
  output logic                                                    err_overrun,
  output logic                                                    err_address
);

  localparam int unsigned OFF_W         = LOG_CORE_COUNT + 2;
  localparam int unsigned COEF_PER_WORD = 1 << OFF_W;
  localparam int unsigned BEAT_W        = LOG_N - OFF_W;
  localparam int unsigned BEATS         = 1 << BEAT_W;
  localparam int unsigned CNT_W         = BEAT_W + 1;

  // One beat word; coefficient j sits at j*COEFF_WIDTH, matching idx[OFF_W-1:0].
  typedef logic [COEF_PER_WORD-1:0][COEFF_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [LOG_N-1:0] issue_idx;
  logic             issue_done;
  logic             s1_valid;
  logic [LOG_N-1:0] s1_idx;
  word_t            s1_word;
  word_t            mem [BEATS];

  logic addr_ok_c, capturing_c, wr_en_c;
  logic out_adv_c, s1_adv_c, rd_en_c;
  logic short_set_c, overrun_set_c, addr_set_c;

  assign addr_ok_c     = in_address < 9'(BEATS);
  assign capturing_c   = in_active && (state != DRAIN);
  assign wr_en_c       = capturing_c && addr_ok_c;
  assign out_adv_c     = !m_valid || m_ready;
  assign s1_adv_c      = !s1_valid || out_adv_c;
  assign rd_en_c       = (state == DRAIN) && s1_adv_c && !issue_done;
  assign short_set_c   = (state == CAPTURE) && !in_active;
  assign overrun_set_c = (state == DRAIN) && in_active;
  assign addr_set_c    = capturing_c && !addr_ok_c;

  // Frame buffer: contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[in_address[BEAT_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en_c) s1_word <= mem[issue_idx[LOG_N-1:OFF_W]];
  end

  // Control FSM, sticky error flags and the two-stage drain pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      issue_idx   <= '0;
      issue_done  <= 1'b0;
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_index     <= '0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
      err_address <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      err_short   <= short_set_c   || (err_short   && !err_clear);
      err_overrun <= overrun_set_c || (err_overrun && !err_clear);
      err_address <= addr_set_c    || (err_address && !err_clear);

      case (state)
        IDLE: begin
          if (in_active) begin
            beat_cnt <= CNT_W'(1);
            state    <= CAPTURE;
            busy     <= 1'b1;
          end
        end

        CAPTURE: begin
          if (!in_active) begin
            beat_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end else if (beat_cnt == CNT_W'(BEATS - 1)) begin
            beat_cnt   <= '0;
            issue_idx  <= '0;
            issue_done <= 1'b0;
            s1_valid   <= 1'b0;
            state      <= DRAIN;
          end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end

        DRAIN: begin
          if (s1_adv_c) begin
            if (!issue_done) begin
              s1_valid <= 1'b1;
              s1_idx   <= issue_idx;
              if (&issue_idx) issue_done <= 1'b1;
              else            issue_idx  <= issue_idx + LOG_N'(1);
            end else begin
              s1_valid <= 1'b0;
            end
          end

          if (m_valid && m_ready && m_last) begin
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (out_adv_c) begin
            m_valid <= s1_valid;
            if (s1_valid) begin
              m_data  <= s1_word[s1_idx[OFF_W-1:0]];
              m_index <= s1_idx;
              m_last  <= &s1_idx;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intt_result_collector.sv
// Self-checking bench for intt_result_collector: scenario table of frames plus a
// short-frame sequence, checked against a flat coefficient-array model.
module tb_intt_result_collector;

  localparam int NC = 4096;

  logic                     clk;
  logic                     rst_n;
  logic                     in_active;
  logic [8:0]               in_address;
  logic [15:0][1:0][59:0]   in_data;
  logic                     err_clear;
  logic                     m_valid;
  logic                     m_ready;
  logic [29:0]              m_data;
  logic [11:0]              m_index;
  logic                     m_last;
  logic                     busy;
  logic                     frame_done;
  logic                     err_short;
  logic                     err_overrun;
  logic                     err_address;

  // Model: coefficient value currently held for every index 0..4095.
  logic [29:0] ref_mem [NC];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rev;
    bit         rnd_data;
    int         bad_beat;
    logic [3:0] pat;       // m_ready pattern by cycle%4; 0 selects random ready
    int         ov_len;
    int         rst_at;
    bit         exp_addr;
    bit         exp_ovr;
  } scen_t;

  scen_t tbl [6];

  intt_result_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_active   (in_active),
    .in_address  (in_address),
    .in_data     (in_data),
    .err_clear   (err_clear),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_index     (m_index),
    .m_last      (m_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_short   (err_short),
    .err_overrun (err_overrun),
    .err_address (err_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input string got_s, input string exp_s);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, got_s, exp_s);
    end
  endtask

  task automatic send_frame(input int nbeats, input bit rev, input bit rnd,
                            input int bad_beat, input bit clr_on_bad);
    int a;
    for (int b = 0; b < nbeats; b++) begin
      a = rev ? 63 - b : b;
      in_active = 1'b1;
      err_clear = 1'b0;
      if (b == bad_beat) begin
        in_address = 9'd100;
        err_clear  = clr_on_bad;
      end else begin
        in_address = 9'(a);
      end
      for (int k = 0; k < 16; k++)
        for (int l = 0; l < 2; l++)
          if (rnd) in_data[k][l] = 60'({$urandom, $urandom});
          else     in_data[k][l] = {30'(a*64 + k*4 + l*2 + 1), 30'(a*64 + k*4 + l*2)};
      if (b != bad_beat)
        for (int k = 0; k < 16; k++)
          for (int l = 0; l < 2; l++) begin
            ref_mem[a*64 + k*4 + l*2]     = in_data[k][l][29:0];
            ref_mem[a*64 + k*4 + l*2 + 1] = in_data[k][l][59:30];
          end
      @(posedge clk); #1;
    end
    in_active = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic drain(input logic [3:0] pat, input int ov_len, input int rst_at,
                       output bit aborted);
    int got, fd_cnt, cyc;
    bit hs, pv, pready, pl;
    logic [29:0] pd;
    logic [11:0] pi;
    got = 0; fd_cnt = 0; cyc = 0;
    hs = 0; pv = 0; pready = 0; pl = 0; pd = '0; pi = '0;
    aborted = 0;
    while (cyc < 20000) begin
      if (frame_done) fd_cnt++;
      if (hs) begin
        chk(pd == ref_mem[got] && pi == 12'(got) && pl == (got == NC - 1), "drain_beat",
            $sformatf("idx %0d data %0h last %0b", pi, pd, pl),
            $sformatf("idx %0d data %0h last %0b", got, ref_mem[got], got == NC - 1));
        got++;
        if (got == NC) break;
      end else if (pv && !pready) begin
        chk(m_valid && m_data == pd && m_index == pi && m_last == pl, "stall_hold",
            $sformatf("v %0b idx %0d data %0h last %0b", m_valid, m_index, m_data, m_last),
            $sformatf("v 1 idx %0d data %0h last %0b", pi, pd, pl));
      end
      if (got == rst_at) begin
        aborted = 1;
        break;
      end
      if (cyc >= 100 && cyc < 100 + ov_len) begin
        in_active  = 1'b1;
        in_address = 9'($urandom_range(0, 63));
        for (int k = 0; k < 16; k++)
          for (int l = 0; l < 2; l++) in_data[k][l] = 60'({$urandom, $urandom});
      end else begin
        in_active = 1'b0;
      end
      m_ready = (pat == 4'b0) ? 1'($urandom) : pat[cyc % 4];
      hs = m_valid && m_ready;
      pv = m_valid; pready = m_ready; pd = m_data; pi = m_index; pl = m_last;
      @(posedge clk); #1;
      cyc++;
    end
    in_active = 1'b0;
    m_ready   = 1'b0;
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      chk(!m_valid && !busy && !m_last && m_index == 12'd0 && !err_address && !err_overrun && !err_short,
          "async_reset",
          $sformatf("v %0b busy %0b last %0b idx %0d errs %0b%0b%0b", m_valid, busy, m_last, m_index,
                    err_short, err_overrun, err_address),
          "all zero");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
    end else if (got < NC) begin
      chk(got == NC, "drain_timeout", $sformatf("%0d handshakes", got), $sformatf("%0d", NC));
    end else begin
      chk(frame_done && !m_valid, "frame_done_pulse",
          $sformatf("done %0b v %0b", frame_done, m_valid), "done 1 v 0");
      chk(fd_cnt == 1, "frame_done_count", $sformatf("%0d", fd_cnt), "1");
      @(posedge clk); #1;
      chk(!frame_done && !busy && !m_valid, "back_to_idle",
          $sformatf("done %0b busy %0b v %0b", frame_done, busy, m_valid), "all 0");
    end
  endtask

  task automatic run_scen(input scen_t s);
    bit aborted;
    send_frame(64, s.rev, s.rnd_data, s.bad_beat, s.bad_beat >= 0);
    chk(busy && err_address == s.exp_addr && !err_short, "capture_done",
        $sformatf("busy %0b err_addr %0b err_short %0b", busy, err_address, err_short),
        $sformatf("busy 1 err_addr %0b err_short 0", s.exp_addr));
    drain(s.pat, s.ov_len, s.rst_at, aborted);
    if (!aborted)
      chk(err_overrun == s.exp_ovr && !err_short, "drain_flags",
          $sformatf("err_ovr %0b err_short %0b", err_overrun, err_short),
          $sformatf("err_ovr %0b err_short 0", s.exp_ovr));
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    chk(!err_short && !err_overrun && !err_address, "err_clear",
        $sformatf("%0b%0b%0b", err_short, err_overrun, err_address), "000");
  endtask

  initial begin
    bit saw_valid;
    tbl[0] = '{rev: 0, rnd_data: 0, bad_beat: -1, pat: 4'b1111, ov_len: 0, rst_at: -1, exp_addr: 0, exp_ovr: 0};
    tbl[1] = '{rev: 1, rnd_data: 0, bad_beat: -1, pat: 4'b1111, ov_len: 0, rst_at: -1, exp_addr: 0, exp_ovr: 0};
    tbl[2] = '{rev: 0, rnd_data: 1, bad_beat: -1, pat: 4'b1001, ov_len: 0, rst_at: -1, exp_addr: 0, exp_ovr: 0};
    tbl[3] = '{rev: 0, rnd_data: 1, bad_beat: -1, pat: 4'b1111, ov_len: 5, rst_at: -1, exp_addr: 0, exp_ovr: 1};
    tbl[4] = '{rev: 0, rnd_data: 1, bad_beat: 10, pat: 4'b0000, ov_len: 0, rst_at: 1000, exp_addr: 1, exp_ovr: 0};
    tbl[5] = '{rev: 1, rnd_data: 1, bad_beat: -1, pat: 4'b0000, ov_len: 0, rst_at: -1, exp_addr: 0, exp_ovr: 0};

    rst_n = 1'b0; in_active = 1'b0; in_address = '0; in_data = '0;
    err_clear = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(!m_valid && !m_last && !busy && !frame_done && !err_short && !err_overrun && !err_address
        && m_data == 30'd0 && m_index == 12'd0, "reset_state",
        $sformatf("v %0b last %0b busy %0b done %0b errs %0b%0b%0b data %0h idx %0d", m_valid, m_last,
                  busy, frame_done, err_short, err_overrun, err_address, m_data, m_index),
        "all zero");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_scen(tbl[i]);

    // Short frame: 40 beats then in_active drops.
    send_frame(40, 1'b0, 1'b1, -1, 1'b0);
    @(posedge clk); #1;
    chk(err_short && !busy, "short_frame",
        $sformatf("err_short %0b busy %0b", err_short, busy), "err_short 1 busy 0");
    saw_valid = 0;
    repeat (10) begin
      if (m_valid) saw_valid = 1;
      @(posedge clk); #1;
    end
    chk(!saw_valid && !busy, "short_no_valid",
        $sformatf("saw_valid %0b busy %0b", saw_valid, busy), "saw_valid 0 busy 0");
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    chk(!err_short, "short_clear", $sformatf("%0b", err_short), "0");

    run_scen(tbl[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
